// File: rtl/tank_joy_pkg.sv
// Purpose: shared types, constants and the joystick-to-lever mapping for the tank joystick mapper.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a (no flow control).
package tank_joy_pkg;

    typedef enum logic [1:0] {
        NEUTRAL = 2'd0,
        FWD     = 2'd1,
        BCK     = 2'd2,
        DEAD    = 2'd3
    } lever_state_t;

    typedef enum logic [1:0] {
        TGT_N = 2'd0,
        TGT_F = 2'd1,
        TGT_B = 2'd2
    } lever_tgt_t;

    // Targets for one player: W is the left lever, X the right lever.
    typedef struct packed {
        lever_tgt_t w;
        lever_tgt_t x;
    } lever_pair_t;

    localparam logic MODE_COMPASS = 1'b0;
    localparam logic MODE_CLASSIC = 1'b1;

    localparam int J_UP    = 3;
    localparam int J_DOWN  = 2;
    localparam int J_LEFT  = 1;
    localparam int J_RIGHT = 0;

    // Joystick vector {up,down,left,right} to lever targets. Opposing
    // directions pressed together are treated as no input.
    function automatic lever_pair_t map_dir(input logic mode, input logic [3:0] vec);
        lever_pair_t r;
        r.w = TGT_N;
        r.x = TGT_N;
        if (!((vec[J_UP] && vec[J_DOWN]) || (vec[J_LEFT] && vec[J_RIGHT]))) begin
            case (vec)
                4'b1000: begin r.w = TGT_F; r.x = TGT_F; end
                4'b0100: begin r.w = TGT_B; r.x = TGT_B; end
                4'b0001: begin r.w = TGT_F; r.x = TGT_B; end
                4'b0010: begin r.w = TGT_B; r.x = TGT_F; end
                4'b1001: begin r.w = TGT_F; r.x = TGT_N; end
                4'b1010: begin r.w = TGT_N; r.x = TGT_F; end
                4'b0101: begin
                    if (mode == MODE_COMPASS) r.w = TGT_B;
                    else                      r.x = TGT_B;
                end
                4'b0110: begin
                    if (mode == MODE_CLASSIC) r.w = TGT_B;
                    else                      r.x = TGT_B;
                end
                default: ;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/tank_lever_fsm.sv
// Purpose: one tank lever; tracks a F/B/N target and inserts neutral dead-time on direct reversals.
// Latency: 1 cycle from target change to registered fw/bk state.
// Backpressure: none; level outputs, a running dead interval always completes.
module tank_lever_fsm
    import tank_joy_pkg::*;
#(
    parameter int DEAD_CYC = 8
)
(
    input  logic       clk_sys,
    input  logic       reset,
    input  lever_tgt_t tgt_i,
    output logic       fw_o,
    output logic       bk_o
);

    localparam int CW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam logic [CW-1:0] DEAD_LOAD = (DEAD_CYC > 0) ? CW'(DEAD_CYC - 1) : '0;

    lever_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    function automatic lever_state_t tgt_state(input lever_tgt_t t);
        case (t)
            TGT_F:   return FWD;
            TGT_B:   return BCK;
            default: return NEUTRAL;
        endcase
    endfunction

    // State and dead-time counter registers.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= NEUTRAL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: reversals detour through DEAD, which counts down to 0 and
    // then follows whatever the target is on that cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            NEUTRAL: state_d = tgt_state(tgt_i);
            FWD: begin
                if (tgt_i == TGT_B) begin
                    if (DEAD_CYC > 0) begin
                        state_d = DEAD;
                        cnt_d   = DEAD_LOAD;
                    end else begin
                        state_d = BCK;
                    end
                end else begin
                    state_d = tgt_state(tgt_i);
                end
            end
            BCK: begin
                if (tgt_i == TGT_F) begin
                    if (DEAD_CYC > 0) begin
                        state_d = DEAD;
                        cnt_d   = DEAD_LOAD;
                    end else begin
                        state_d = FWD;
                    end
                end else begin
                    state_d = tgt_state(tgt_i);
                end
            end
            DEAD: begin
                if (cnt_q == '0) state_d = tgt_state(tgt_i);
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = NEUTRAL;
        endcase
    end

    // Output decode straight from the state register, so fw and bk are exclusive.
    always_comb begin
        fw_o = (state_q == FWD);
        bk_o = (state_q == BCK);
    end

endmodule

// File: rtl/tank_joy_mapper.sv
// Purpose: per-player joystick filter, tank lever mapping with reversal dead-time, and optional autofire.
// Latency: levers FILT_CYC+1 cycles from a stable joystick (1 from accepted vector); fire 1 cycle.
// Backpressure: none; all inputs are sampled every cycle and outputs are levels.
module tank_joy_mapper
    import tank_joy_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int FILT_CYC    = 4,
    parameter int DEAD_CYC    = 8,
    parameter int AUTO_HALF   = 16
)
(
    input  logic [4*NUM_PLAYERS-1:0] joy_i,
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic [NUM_PLAYERS-1:0]   fire_i,
    input  logic                     mode_i,
    input  logic                     autofire_en_i,
    output logic [2*NUM_PLAYERS-1:0] lever_fw_o,
    output logic [2*NUM_PLAYERS-1:0] lever_bk_o,
    output logic [NUM_PLAYERS-1:0]   fire_o
);

    localparam int FCW = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
    localparam logic [FCW-1:0] FILT_LAST = (FILT_CYC > 0) ? FCW'(FILT_CYC - 1) : '0;
    localparam int ACW = (AUTO_HALF > 1) ? $clog2(AUTO_HALF) : 1;
    localparam logic [ACW-1:0] AUTO_LAST = ACW'(AUTO_HALF - 1);

    logic [4*NUM_PLAYERS-1:0] cand_q, cand_d;
    logic [4*NUM_PLAYERS-1:0] acc_q, acc_d;
    logic [FCW-1:0]           filt_cnt_q [NUM_PLAYERS];
    logic [FCW-1:0]           filt_cnt_d [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0]   fire_q, fire_d;
    logic [NUM_PLAYERS-1:0]   fire_prev_q, fire_prev_d;
    logic                     af_en_prev_q, af_en_prev_d;
    logic [ACW-1:0]           ph_q [NUM_PLAYERS];
    logic [ACW-1:0]           ph_d [NUM_PLAYERS];

    // Stability filter: the counter tracks how long joy_i has matched the
    // previous sample; the vector is accepted once that run reaches FILT_CYC.
    always_comb begin
        cand_d = joy_i;
        acc_d  = acc_q;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            filt_cnt_d[p] = '0;
            if (FILT_CYC == 0) begin
                acc_d[4*p +: 4] = joy_i[4*p +: 4];
            end else begin
                if (joy_i[4*p +: 4] == cand_q[4*p +: 4]) begin
                    filt_cnt_d[p] = (filt_cnt_q[p] == FILT_LAST) ? FILT_LAST
                                                                 : filt_cnt_q[p] + 1'b1;
                end
                if (filt_cnt_d[p] == FILT_LAST) acc_d[4*p +: 4] = joy_i[4*p +: 4];
            end
        end
    end

    // Fire path: plain 1-cycle register, or autofire that starts high on a
    // fresh press (or fresh enable) and toggles every AUTO_HALF cycles.
    always_comb begin
        fire_d       = '0;
        fire_prev_d  = fire_i;
        af_en_prev_d = autofire_en_i;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            ph_d[p] = '0;
            if (!autofire_en_i) begin
                fire_d[p] = fire_i[p];
            end else if (fire_i[p]) begin
                if (!fire_prev_q[p] || !af_en_prev_q) begin
                    fire_d[p] = 1'b1;
                end else if (ph_q[p] == AUTO_LAST) begin
                    fire_d[p] = ~fire_q[p];
                end else begin
                    fire_d[p] = fire_q[p];
                    ph_d[p]   = ph_q[p] + 1'b1;
                end
            end
        end
    end

    // Filter and fire registers; reset returns everything to neutral/idle.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cand_q       <= '0;
            acc_q        <= '0;
            fire_q       <= '0;
            fire_prev_q  <= '0;
            af_en_prev_q <= 1'b0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                filt_cnt_q[p] <= '0;
                ph_q[p]       <= '0;
            end
        end else begin
            cand_q       <= cand_d;
            acc_q        <= acc_d;
            fire_q       <= fire_d;
            fire_prev_q  <= fire_prev_d;
            af_en_prev_q <= af_en_prev_d;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                filt_cnt_q[p] <= filt_cnt_d[p];
                ph_q[p]       <= ph_d[p];
            end
        end
    end

    assign fire_o = fire_q;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        lever_pair_t tgt;
        assign tgt = map_dir(mode_i, acc_q[4*p +: 4]);

        tank_lever_fsm #(.DEAD_CYC(DEAD_CYC)) u_lever_w (
            .clk_sys (clk_sys),
            .reset   (reset),
            .tgt_i   (tgt.w),
            .fw_o    (lever_fw_o[2*p]),
            .bk_o    (lever_bk_o[2*p])
        );

        tank_lever_fsm #(.DEAD_CYC(DEAD_CYC)) u_lever_x (
            .clk_sys (clk_sys),
            .reset   (reset),
            .tgt_i   (tgt.x),
            .fw_o    (lever_fw_o[2*p+1]),
            .bk_o    (lever_bk_o[2*p+1])
        );
    end

endmodule

// File: tb/tb_tank_joy_mapper.sv
// Purpose: directed scoreboard bench for tank_joy_mapper with default parameters (2 players).
// Latency: each step's expectation applies to the outputs right after that step's clock edge.
// Backpressure: n/a.
module tb_tank_joy_mapper;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic [7:0] joy_i;
    logic [1:0] fire_i;
    logic       mode_i;
    logic       autofire_en_i;
    logic [3:0] lever_fw_o;
    logic [3:0] lever_bk_o;
    logic [1:0] fire_o;

    typedef struct packed {
        logic [3:0] fw;
        logic [3:0] bk;
        logic [1:0] fi;
    } exp_t;

    exp_t  exp_q [$];
    string name_q [$];
    int    total = 0;
    int    bad   = 0;

    always #5 clk_sys = ~clk_sys;

    tank_joy_mapper dut (
        .joy_i         (joy_i),
        .clk_sys       (clk_sys),
        .reset         (reset),
        .fire_i        (fire_i),
        .mode_i        (mode_i),
        .autofire_en_i (autofire_en_i),
        .lever_fw_o    (lever_fw_o),
        .lever_bk_o    (lever_bk_o),
        .fire_o        (fire_o)
    );

    // Drive one cycle of inputs away from the active edge and queue what the
    // outputs must be just after the coming rising edge.
    task automatic step(input logic r, input logic [7:0] j, input logic [1:0] f,
                        input logic m, input logic af,
                        input logic [3:0] efw, input logic [3:0] ebk, input logic [1:0] efi,
                        input string nm);
        exp_t e;
        @(negedge clk_sys);
        reset         = r;
        joy_i         = j;
        fire_i        = f;
        mode_i        = m;
        autofire_en_i = af;
        e.fw = efw;
        e.bk = ebk;
        e.fi = efi;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: one expectation per rising edge, checked 1 time unit later.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk_sys);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                total++;
                if (lever_fw_o !== e.fw || lever_bk_o !== e.bk || fire_o !== e.fi) begin
                    bad++;
                    $display("FAIL %s @%0t: got fw=%b bk=%b fire=%b, want fw=%b bk=%b fire=%b",
                             nm, $time, lever_fw_o, lever_bk_o, fire_o, e.fw, e.bk, e.fi);
                end
            end
        end
    end

    initial begin
        logic [1:0] ftab [8];
        ftab[0] = 2'b01; ftab[1] = 2'b11; ftab[2] = 2'b10; ftab[3] = 2'b00;
        ftab[4] = 2'b01; ftab[5] = 2'b00; ftab[6] = 2'b11; ftab[7] = 2'b00;

        reset = 1'b1; joy_i = '0; fire_i = '0; mode_i = 1'b0; autofire_en_i = 1'b0;

        // Reset state
        for (int k = 0; k < 2; k++)
            step(1, 8'h00, 2'b00, 0, 0, 4'h0, 4'h0, 2'b00, "reset");

        // P0 up from neutral: levers forward 5 cycles after first sample
        for (int k = 0; k < 12; k++)
            step(0, 8'h08, 2'b00, 0, 0, (k >= 4) ? 4'b0011 : 4'b0000, 4'h0, 2'b00, "p0_up");

        // P0 up -> down: filter delay, 8 neutral cycles, then back
        for (int k = 0; k < 16; k++)
            step(0, 8'h04, 2'b00, 0, 0, (k <= 3) ? 4'b0011 : 4'b0000,
                 (k >= 12) ? 4'b0011 : 4'b0000, 2'b00, "p0_reverse");

        // P0 back to neutral: no dead-time on release
        for (int k = 0; k < 8; k++)
            step(0, 8'h00, 2'b00, 0, 0, 4'h0, (k <= 3) ? 4'b0011 : 4'b0000, 2'b00, "p0_release");

        // P0 up + P1 down-right, compass: P1 W back only
        for (int k = 0; k < 8; k++)
            step(0, 8'h58, 2'b00, 0, 0, (k >= 4) ? 4'b0011 : 4'b0000,
                 (k >= 4) ? 4'b0100 : 4'b0000, 2'b00, "p1_dr_compass");

        // Switch to classic: P1 X back only on the next edge, P0 unaffected
        for (int k = 0; k < 6; k++)
            step(0, 8'h58, 2'b00, 1, 0, 4'b0011, 4'b1000, 2'b00, "p1_dr_classic");

        // Release all players
        for (int k = 0; k < 8; k++)
            step(0, 8'h00, 2'b00, 1, 0, (k <= 3) ? 4'b0011 : 4'b0000,
                 (k <= 3) ? 4'b1000 : 4'b0000, 2'b00, "release_all");

        // Glitch shorter than the filter window is ignored
        for (int k = 0; k < 3; k++)
            step(0, 8'h01, 2'b00, 0, 0, 4'h0, 4'h0, 2'b00, "glitch");
        for (int k = 0; k < 8; k++)
            step(0, 8'h00, 2'b00, 0, 0, 4'h0, 4'h0, 2'b00, "glitch_after");

        // Opposing directions held: neutral
        for (int k = 0; k < 10; k++)
            step(0, 8'h3C, 2'b00, 0, 0, 4'h0, 4'h0, 2'b00, "invalid_vec");
        for (int k = 0; k < 5; k++)
            step(0, 8'h00, 2'b00, 0, 0, 4'h0, 4'h0, 2'b00, "invalid_clear");

        // Autofire on P0: 16 high, 16 low, repeating
        for (int k = 0; k < 70; k++)
            step(0, 8'h00, 2'b01, 0, 1, 4'h0, 4'h0, {1'b0, ((k / 16) % 2) == 0}, "autofire");
        for (int k = 0; k < 4; k++)
            step(0, 8'h00, 2'b00, 0, 1, 4'h0, 4'h0, 2'b00, "af_release");

        // Autofire off: fire follows input by one cycle
        for (int k = 0; k < 8; k++)
            step(0, 8'h00, ftab[k], 0, 0, 4'h0, 4'h0, ftab[k], "fire_follow");

        // Enabling autofire mid-hold restarts the phase high
        for (int k = 0; k < 4; k++)
            step(0, 8'h00, 2'b10, 0, 0, 4'h0, 4'h0, 2'b10, "fire1_hold");
        for (int k = 0; k < 20; k++)
            step(0, 8'h00, 2'b10, 0, 1, 4'h0, 4'h0, (k < 16) ? 2'b10 : 2'b00, "af_toggle");
        for (int k = 0; k < 2; k++)
            step(0, 8'h00, 2'b00, 0, 0, 4'h0, 4'h0, 2'b00, "fire1_release");

        // Reset during a dead interval and during autofire, then recovery
        for (int t = 0; t < 26; t++)
            step((t == 12) || (t == 13), (t < 6) ? 8'h08 : 8'h04, 2'b01, 0, 1,
                 (t >= 4 && t <= 9) ? 4'b0011 : 4'b0000,
                 (t >= 18) ? 4'b0011 : 4'b0000,
                 (t < 12 || t >= 14) ? 2'b01 : 2'b00, "reset_mid");

        @(posedge clk_sys);
        #3;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tank_joy_mapper.md
Name: tank_joy_mapper

Overview:
- Converts digital 4-way joysticks into dual-lever tank controls for NUM_PLAYERS players. Each player drives a left lever (W) and a right lever (X), each with Fw/Bk outputs.
- Adds sequential behaviour on top of the mapping:
  - stability filtering of the joystick vector
  - forced neutral dead-time on any lever reversal
  - optional autofire
- Sits in the emu top between hps_io joystick words and the core's active-low lever inputs. The top performs the inversion.

Parameters:
- NUM_PLAYERS, 2, number of player channels (1..4).
- FILT_CYC, 4, consecutive clk_sys cycles a joystick vector must be stable before acceptance; 0 = bypass.
- DEAD_CYC, 8, neutral cycles inserted on a direct Fw<->Bk lever reversal; 0 = no dead-time.
- AUTO_HALF, 16, autofire half-period in clk_sys cycles; must be >=1.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- joy_i  in  4*NUM_PLAYERS  per player p at [4p+3:4p] = {up,down,left,right}, active-high.
- fire_i  in  NUM_PLAYERS  fire buttons, active-high.
- mode_i  in  1  0 = COMPASS map, 1 = CLASSIC map; shared by all players.
- autofire_en_i  in  1  enables autofire on all players.
- lever_fw_o  out  2*NUM_PLAYERS  bit 2p = W Fw, bit 2p+1 = X Fw, active-high.
- lever_bk_o  out  2*NUM_PLAYERS  same indexing, Bk.
- fire_o  out  NUM_PLAYERS  processed fire, active-high.

Behaviour:
- Reset (synchronous, active-high):
  - All outputs are 0.
  - Accepted vectors, candidate vectors, counters and lever FSMs are cleared to NEUTRAL.
  - Reset mid-dead-time or mid-autofire aborts immediately.
- Filter, per player:
  - The candidate register samples joy_i every cycle.
  - The stability counter resets to 0 whenever joy_i differs from the candidate.
  - The accepted vector updates when the counter reaches FILT_CYC-1 with an unchanged input. A vector held FILT_CYC cycles is therefore accepted.
  - With FILT_CYC=0, accepted = joy_i registered, 1 cycle.
- Map (combinational on the accepted vector), giving per-lever targets F/B/N as W,X:
  - Both modes:
    - up = F,F
    - down = B,B
    - right = F,B
    - left = B,F
    - up-right = F,N
    - up-left = N,F
  - COMPASS: down-right = B,N; down-left = N,B.
  - CLASSIC: down-right = N,B; down-left = B,N.
  - Any vector with up&down or left&right, and 0000, map to N,N.
- Lever FSM, one per lever. States NEUTRAL, FWD, BCK, DEAD.
  - Outputs: FWD gives fw=1; BCK gives bk=1; NEUTRAL and DEAD give both 0.
  - fw and bk are never both 1.
  - NEUTRAL goes to FWD or BCK on the matching target, next cycle.
  - FWD with target B, and BCK with target F:
    - go to DEAD and load the counter with DEAD_CYC-1, when DEAD_CYC>0
    - go directly to the opposite state when DEAD_CYC=0
  - FWD or BCK with target N goes to NEUTRAL.
  - DEAD always runs to completion. On the counter reaching 0 it moves to the state for the target current at that cycle.
  - Exactly DEAD_CYC cycles of neutral output are produced on a reversal.
  - Outputs are registered.
  - Latency from accepted-vector change to lever output is 1 cycle. Total from joy_i, FILT_CYC>0, no reversal, is FILT_CYC+1 cycles.
- Fire, no filter:
  - autofire_en_i=0: fire_o = fire_i registered, 1 cycle.
  - autofire_en_i=1 while fire_i held: fire_o goes 1 on the cycle after the press, then toggles every AUTO_HALF cycles.
  - Release forces fire_o=0 next cycle and clears the phase counter.
  - Toggling autofire_en_i mid-hold restarts the phase with fire_o=1.
- mode_i change: takes effect on the next mapping evaluation. Resulting reversals obey dead-time.
- Players are fully independent. Simultaneous events on different players have no interaction.

Decomposition:
- Package tank_joy_pkg:
  - lever_state_t enum (NEUTRAL, FWD, BCK, DEAD)
  - lever_tgt_t enum (TGT_N, TGT_F, TGT_B)
  - MODE_COMPASS/MODE_CLASSIC constants
  - joystick bit-index constants (J_UP=3, J_DOWN=2, J_LEFT=1, J_RIGHT=0)
  - mapping function map_dir(mode, vec4) returning two targets
- Sub-module tank_lever_fsm: one lever FSM plus dead-time counter, parameter DEAD_CYC. Instantiated 2*NUM_PLAYERS times via generate.
- Filter and autofire stay in tank_joy_mapper.

Test Plan:
- Defaults; hold P0 joy=1000 (up) from cycle 0 -> lever_fw_o[1:0]=11 at cycle 5; lever_bk_o=0.
- P0 up held, then joy=0100 (down) -> fw drops to 00 after filter; levers neutral exactly 8 cycles; then lever_bk_o[1:0]=11.
- P1 joy=0101 (down-right), mode_i=0 -> W Bk only (bk[2]=1). mode_i=1 -> X Bk only (bk[3]=1), with 8-cycle dead where applicable. P0 outputs unaffected.
- Glitch: P0 joy=0001 for 3 cycles, then 0000 -> outputs never change. Invalid vector 1100 held 10 cycles -> all levers neutral.
- autofire_en_i=1, fire_i[0] held 70 cycles:
  - fire_o[0] pattern is 16 high, 16 low, repeating, starting the cycle after the press.
  - Release -> 0 next cycle.
  - With autofire off -> fire_o follows fire_i with 1-cycle delay.
- Assert reset during a DEAD interval and during autofire -> all outputs 0 the next cycle. After release with joy stable -> normal acceptance after FILT_CYC+1 cycles.
